// File: rtl/serial_tx.sv
// -----------------------------------------------------------------------------
// serial_tx
//   Parallel-in / serial-out frame transmitter. A word offered on din with load
//   is accepted while idle and sent as: start bit (0), WIDTH data bits LSB
//   first, stop bit (1). Each bit is held for CLKS_PER_BIT clocks. Every line
//   transition is launched on posedge clk so a receiver sampling on the falling
//   edge sees half a period of setup.
//
// Ports
//   clk    in   1      clock, all state updates on posedge
//   rst    in   1      synchronous reset, active-high
//   din    in   WIDTH  parallel word, sampled only at the accept edge
//   load   in   1      producer valid; accepted when load && ready at posedge
//   ready  out  1      idle and able to accept a word (masked by rst)
//   sout   out  1      serial line, idles high (registered)
//   busy   out  1      high while START/DATA/STOP is on the line (registered)
//   done   out  1      one-cycle pulse in the first idle cycle after a frame
// -----------------------------------------------------------------------------
module serial_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic               sout_q,  sout_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic               bit_end_s;

  // ready is combinational so a word can be accepted in the done cycle.
  assign ready = (state_q == IDLE) && !rst;
  assign sout  = sout_q;
  assign busy  = busy_q;
  assign done  = done_q;

  // Next-state, counter, shift-register and output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    done_d    = 1'b0;
    bit_end_s = (cnt_q == CNT_LAST);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (load) begin
          shreg_d = din;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end

      START: begin
        if (bit_end_s) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DATA: begin
        if (bit_end_s) begin
          cnt_d   = '0;
          // Shift so the next bit to send always sits in shreg[0].
          shreg_d = shreg_q >> 1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      STOP: begin
        if (bit_end_s) begin
          cnt_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Outputs are derived from the next state so they change on the same
    // edge as the state register.
    case (state_d)
      START:   sout_d = 1'b0;
      DATA:    sout_d = shreg_d[0];
      default: sout_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      sout_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
module tb_serial_tx;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] din;
  logic       ready, sout, busy, done;

  logic       rst_b;
  logic       load_b;
  logic [3:0] din_b;
  logic       ready_b, sout_b, busy_b, done_b;

  int n_checks;
  int n_fail;

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst(rst), .din(din), .load(load),
    .ready(ready), .sout(sout), .busy(busy), .done(done)
  );

  serial_tx #(.WIDTH(4), .CLKS_PER_BIT(1)) dut_b (
    .clk(clk), .rst(rst_b), .din(din_b), .load(load_b),
    .ready(ready_b), .sout(sout_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row = inputs held for n cycles; ready checked before each edge,
  // sout/busy/done checked just after each edge.
  typedef struct {
    logic       rst;
    logic       load;
    logic [7:0] din;
    int         n;
    logic       sout;
    logic       busy;
    logic       done;
    logic       ready;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic l, input logic [7:0] d,
                              input int n, input logic s, input logic b,
                              input logic dn, input logic rdy);
    vec_t v;
    v.rst = r; v.load = l; v.din = d; v.n = n;
    v.sout = s; v.busy = b; v.done = dn; v.ready = rdy;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d t=%0t: got %b expected %b", name, idx, $time, act, exp);
    end
  endtask

  logic [5:0] exp_b;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; load = 1'b0; din = 8'h00;
    rst_b = 1'b1; load_b = 1'b0; din_b = 4'h0;

    // Test 1: reset then idle
    add(1'b1, 1'b0, 8'h00, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h00, 5, 1'b1, 1'b0, 1'b0, 1'b1);
    // Test 2: single frame of 8'hA5 (LSB first 1,0,1,0,0,1,0,1)
    add(1'b0, 1'b1, 8'hA5, 1, 1'b0, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 8'hA5, 3, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'hA5, 4, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'hA5, 4, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'hA5, 4, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'hA5, 4, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'hA5, 4, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'hA5, 4, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'hA5, 4, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'hA5, 4, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'hA5, 4, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'hA5, 1, 1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 8'hA5, 3, 1'b1, 1'b0, 1'b0, 1'b1);
    // Test 3: same frame, din change + load pulse at edge t0+10 ignored
    add(1'b0, 1'b1, 8'hA5, 1, 1'b0, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 8'hA5, 3, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'hA5, 4, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'hA5, 2, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h3C, 1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h3C, 1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h3C, 4, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h3C, 4, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h3C, 4, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h3C, 4, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h3C, 4, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h3C, 4, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h3C, 4, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h3C, 1, 1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 8'h3C, 3, 1'b1, 1'b0, 1'b0, 1'b1);
    // Test 4: load held high, 8'h00 then 8'hFF back-to-back
    add(1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b1, 8'hFF, 35, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'hFF, 4, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'hFF, 1, 1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 8'hFF, 1, 1'b0, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 8'hFF, 3, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'hFF, 36, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'hFF, 1, 1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 8'hFF, 2, 1'b1, 1'b0, 1'b0, 1'b1);
    // Test 5: reset at edge t0+20, new frame of 8'h0F at edge t0+23
    add(1'b0, 1'b1, 8'h0F, 1, 1'b0, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 8'h0F, 3, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h0F, 16, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 8'h0F, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h0F, 2, 1'b1, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 8'h0F, 1, 1'b0, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 8'h0F, 3, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h0F, 16, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h0F, 16, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h0F, 4, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h0F, 1, 1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 8'h0F, 2, 1'b1, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int c = 0; c < vecs[i].n; c++) begin
        @(negedge clk);
        rst  = vecs[i].rst;
        load = vecs[i].load;
        din  = vecs[i].din;
        #1;
        chk("ready", i, ready, vecs[i].ready);
        @(posedge clk);
        #1;
        chk("sout", i, sout, vecs[i].sout);
        chk("busy", i, busy, vecs[i].busy);
        chk("done", i, done, vecs[i].done);
      end
    end

    // Test 6: CLKS_PER_BIT=1, WIDTH=4, din=4'b0110 -> 0,0,1,1,0,1 then done
    exp_b = 6'b101100;
    @(negedge clk);
    rst = 1'b0; load = 1'b0;
    rst_b = 1'b0; load_b = 1'b1; din_b = 4'b0110;
    #1;
    chk("b_ready_idle", 0, ready_b, 1'b1);
    @(posedge clk);
    #1;
    chk("b_sout", 0, sout_b, exp_b[0]);
    chk("b_busy", 0, busy_b, 1'b1);
    for (int k = 1; k < 6; k++) begin
      @(negedge clk);
      load_b = 1'b0;
      din_b  = 4'b1001;
      @(posedge clk);
      #1;
      chk("b_sout", k, sout_b, exp_b[k]);
      chk("b_busy", k, busy_b, 1'b1);
      chk("b_done", k, done_b, 1'b0);
    end
    @(posedge clk);
    #1;
    chk("b_done_pulse", 6, done_b, 1'b1);
    chk("b_sout_idle", 6, sout_b, 1'b1);
    chk("b_busy_idle", 6, busy_b, 1'b0);
    @(posedge clk);
    #1;
    chk("b_done_clear", 7, done_b, 1'b0);
    chk("b_sout_hold", 7, sout_b, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
